// File: rtl/systolic_input_feeder.sv
// systolic_input_feeder
//   West-edge feeder for the systolic array. Vectors (one element per array
//   row) are accepted on a valid/ready handshake into a small FIFO, then
//   issued one per cycle (or as a bubble when nothing is poppable) into a
//   per-row skew pipeline so row r sees its element r cycles after row 0.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   in_valid/ready  upstream handshake; in_ready is low while rst is high
//   in_data         N lanes, lane r = bits [r*DATA_WIDTH +: DATA_WIDTH]
//   in_switch       weight-switch tag travelling with the vector
//   feed_en         allows popping the FIFO head into the skew pipeline
//   out_input       per-row PE input, same lane packing as in_data
//   out_valid       per-row PE valid
//   out_switch      per-row PE switch, aligned with the tagged element
//   busy            FIFO non-empty or any skew stage holds a valid entry

// One row of the skew pipeline: LAT registers (LAT-1 delay stages plus the
// output register). Data, valid and switch share stages so they stay aligned.
module sif_skew_lane #(
  parameter int DW  = 16,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_switch,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          out_switch,
  output logic          any_valid
);
  logic [LAT-1:0]         vld_pipe;
  logic [LAT-1:0]         sw_pipe;
  logic [LAT-1:0][DW-1:0] dat_pipe;

  // Shifts every cycle regardless of feed_en; bubbles carry zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      sw_pipe  <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_valid;
      sw_pipe[0]  <= in_switch;
      dat_pipe[0] <= in_data;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        sw_pipe[i]  <= sw_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign out_data   = dat_pipe[LAT-1];
  assign out_valid  = vld_pipe[LAT-1];
  assign out_switch = sw_pipe[LAT-1];
  assign any_valid  = |vld_pipe;
endmodule

module systolic_input_feeder #(
  parameter int N          = 2,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  input  logic                  in_switch,
  input  logic                  feed_en,
  output logic [N*DATA_WIDTH-1:0] out_input,
  output logic [N-1:0]          out_valid,
  output logic [N-1:0]          out_switch,
  output logic                  busy
);
  localparam int AW = $clog2(DEPTH);

  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;
  typedef struct packed {
    logic sw;
    vec_t lanes;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  entry_t        head;

  // Ready is driven from the registered count only: a full FIFO refuses
  // even when a pop is happening in the same cycle.
  assign in_ready = !rst && (count < (AW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = feed_en && (count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{sw: in_switch, lanes: vec_t'(in_data)};
  end

  assign head = mem[rd_ptr];

  // Issue slot: head entry on pop, otherwise an all-zero bubble so PE psums
  // stay at zero on invalid slots.
  logic       slot_vld, slot_sw;
  vec_t       slot_lanes;
  assign slot_vld   = pop;
  assign slot_sw    = pop && head.sw;
  assign slot_lanes = pop ? head.lanes : '0;

  logic [N-1:0] lane_busy;

  for (genvar r = 0; r < N; r++) begin : g_lane
    sif_skew_lane #(
      .DW  (DATA_WIDTH),
      .LAT (r + 1)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .in_data    (slot_lanes[r]),
      .in_valid   (slot_vld),
      .in_switch  (slot_sw),
      .out_data   (out_input[r*DATA_WIDTH +: DATA_WIDTH]),
      .out_valid  (out_valid[r]),
      .out_switch (out_switch[r]),
      .any_valid  (lane_busy[r])
    );
  end

  assign busy = (count != '0) || (|lane_busy);
endmodule

// File: doc/systolic_input_feeder.md
# systolic_input_feeder

West-edge feeder for the systolic array. It accepts one activation vector per handshake (one element per array row) and buffers vectors in a small FIFO. It drives the `pe_input_in`, `pe_valid_in` and `pe_switch_in` wires of each row's column-0 PE. Row r is delayed by r cycles, producing the diagonal wavefront the PE grid needs. When no data is available it inserts a bubble, so the array is never stalled.

## Interface
- `N`, 2, number of array rows (lanes), ≥1
- `DATA_WIDTH`, 16, signed element width, Q-format shared with `fxp_mul`/`fxp_add`
- `DEPTH`, 4, FIFO entries, power of two, ≥2
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  upstream has a vector on `in_data`
- `in_ready`  out  1  feeder accepts a vector this cycle
- `in_data`  in  N*DATA_WIDTH  lane r = bits [r*DATA_WIDTH +: DATA_WIDTH], signed
- `in_switch`  in  1  vector is the first one using newly loaded weights; travels with the vector
- `feed_en`  in  1  permit popping vectors into the array
- `out_input`  out  N*DATA_WIDTH  to row r `pe_input_in`, same lane packing
- `out_valid`  out  N  to row r `pe_valid_in`
- `out_switch`  out  N  to row r `pe_switch_in`
- `busy`  out  1  FIFO non-empty or any skew stage holds a valid entry

## Operation
- FIFO entry = {switch, N lanes}. Push when `in_valid && in_ready`. `in_ready` = `!rst && count < DEPTH`, combinational from the registered count. A full FIFO has no pass-through.
- Pop condition `pop = feed_en && count != 0`, evaluated each cycle.
- Issue slot each cycle:
  - If `pop`: the slot carries {valid=1, switch, lanes} of the head entry.
  - Otherwise: a bubble {valid=0, switch=0, lanes=0}.
- Skew pipeline: lane r passes through r+1 registers. Lane 0 has one output register. Lane r has r delay stages plus the output register.
  - `out_input[r]`, `out_valid[r]` and `out_switch[r]` all come from the same stage, so they stay aligned.
  - The pipeline shifts every cycle unconditionally, including when `feed_en`=0.
- Bubble lanes always output data 0. This keeps PE psums at 0 on invalid slots.
- Simultaneous push and pop: count unchanged. This is legal at count=DEPTH only if the pop occurs, but `in_ready` is 0 at full, so no push happens then.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Data is not modified: no saturation, no sign manipulation.
- `busy` = `count != 0 || |valid bits in all skew stages`.

## Timing
- Reset (async assert): FIFO empty, pointers 0, all skew stages 0, `out_input`=0, `out_valid`=0, `out_switch`=0, `busy`=0, `in_ready`=0 while `rst` is high.
- Release: `in_ready`=1 from the first cycle after `rst` falls.
- A vector accepted at edge E0 is first poppable in the cycle after E0. With `feed_en`=1 and the vector at head, lane r appears at outputs after edge E0+1+r.
- Throughput: one vector per cycle sustained when push and pop occur every cycle.
- `feed_en` deasserted: no pop. Already-issued entries keep draining the skew, so lane r's last valid appears up to r cycles after `feed_en` falls.
- Reset mid-operation: all buffered and in-flight vectors are discarded immediately. No partial wavefront is emitted after release.
- `out_switch[r]` is high exactly in the cycle `out_valid[r]` carries the tagged vector. This matches the PE rule that the switch is combinational on the same cycle as the first input.

## Test plan
- Reset: assert `rst` mid-stream with 3 vectors queued and 2 in skew. Required: all outputs 0 and `busy`=0 within the same cycle; `in_ready`=0 while `rst` is high, 1 after release; no stale valid afterwards.
- Single vector, N=2, lanes {0x0100, 0xFF00}, `feed_en`=1, accepted at E0. Required: lane0=0x0100 with `out_valid[0]` after E0+1; lane1=0xFF00 with `out_valid[1]` after E0+2; outputs 0 in all other cycles.
- Stream of 6 back-to-back vectors with `in_switch` on the first only. Required: `out_valid` high for 6 consecutive cycles per lane, lane r offset by r; `out_switch[r]` high only on vector 0's cycle.
- Backpressure: `feed_en`=0, push 5 vectors. Required: `in_ready` drops after the 4th; 5th held until `feed_en`=1; then all 5 emerge in order.
- Empty gap: push vectors A and B with 2 idle cycles between. Required: each lane shows A, two bubbles (valid=0, data=0), then B.
- Pointer wrap: 3×DEPTH vectors with random `feed_en` toggling. Required: output order and data match a scoreboard exactly.
